// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single-port data_mem between the core load/store path (port 0)
//   and the loader/DMA path (port 1). One access is accepted per cycle with
//   round-robin arbitration. The winning command is registered onto the memory
//   control pins. Read data is captured from the memory's combinational output
//   one cycle later and returned to the originating port with a valid pulse.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   pX_req/we/addr/wdata requester X command (held until pX_gnt)
//   pX_gnt              combinational grant, same cycle as the request
//   pX_rvalid/rdata     registered read return, 2 cycles after grant
//   mem_addr/read/write/wdata  registered command to data_mem
//   mem_rdata           data_mem output, only meaningful while mem_read = 1
// ---------------------------------------------------------------------------

// Per-port read-return register: captures memory data only for reads that
// belong to this port, so the other port's return state is untouched.
module data_mem_arbiter_rport #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_capture;
      // bus is high-Z outside read cycles; never sample it then
      if (i_capture) r_rdata <= i_mem_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]             w_req, w_we, w_gnt, w_cap, w_rvalid;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_wdata, w_rdata;
  logic                             w_sel;

  logic              r_last_gnt;  // port granted most recently
  logic              r_src;       // owner of the command now on the pins
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read, r_mem_write;

  assign w_req   = {p1_req,   p0_req};
  assign w_we    = {p1_we,    p0_we};
  assign w_addr  = {p1_addr,  p0_addr};
  assign w_wdata = {p1_wdata, p0_wdata};

  // Round robin: a lone requester always wins; under contention the port
  // that did not win last time goes first. Grants are masked during reset.
  always_comb begin
    w_gnt = '0;
    if (!reset) begin
      if (w_req[0] && (!w_req[1] || r_last_gnt)) w_gnt[0] = 1'b1;
      else if (w_req[1])                         w_gnt[1] = 1'b1;
    end
  end

  assign w_sel  = w_gnt[1];
  assign p0_gnt = w_gnt[0];
  assign p1_gnt = w_gnt[1];

  // Command stage. Reset clears read/write so an in-flight command never
  // reaches the memory edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_gnt  <= 1'b1;
      r_src       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (|w_gnt) begin
      r_last_gnt  <= w_sel;
      r_src       <= w_sel;
      r_mem_addr  <= w_addr[w_sel];
      r_mem_wdata <= w_wdata[w_sel];
      r_mem_read  <= ~w_we[w_sel];
      r_mem_write <= w_we[w_sel];
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign w_cap[i] = r_mem_read && (r_src == 1'(i));

    data_mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
      .clk        (clk),
      .reset      (reset),
      .i_capture  (w_cap[i]),
      .i_mem_rdata(mem_rdata),
      .o_rvalid   (w_rvalid[i]),
      .o_rdata    (w_rdata[i])
    );
  end

  assign p0_rvalid = w_rvalid[0];
  assign p1_rvalid = w_rvalid[1];
  assign p0_rdata  = w_rdata[0];
  assign p1_rdata  = w_rdata[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic       mem_read, mem_write;
  wire  [7:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data_mem stand-in: combinational read, write at clock edge
  logic       pre_en;
  logic [7:0] dmem [256];
  always @(posedge clk) begin
    if (pre_en) for (int i = 0; i < 256; i++) dmem[i] <= 8'(i) ^ 8'hC3;
    else if (mem_write) dmem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_read ? dmem[mem_addr] : 'z;

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed { logic v, port, we; logic [7:0] addr, data; } txn_t;
  typedef struct packed {
    logic r0, w0; logic [7:0] a0, d0;
    logic r1, w1; logic [7:0] a1, d1;
    logic eg0, eg1, erv0, erv1;
    logic [1:0] erp; logic [7:0] erd;
  } vec_t;

  txn_t       pipe_q[$];      // grants of the previous two cycles, oldest first
  logic [7:0] ref_mem [256];
  logic       m_last;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] exp_rd [2];
  logic       eg0, eg1;
  logic       act_g0, act_g1, act_rv0, act_rv1;
  logic [7:0] act_rd0, act_rd1;
  int         total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    pipe_q.push_back('0);
    pipe_q.push_back('0);
    m_last = 1'b1; m_addr = '0; m_wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  // Effects happen in grant order; a grant's result is visible two cycles on.
  task automatic eval_check();
    txn_t old, prev;
    logic erv0, erv1;
    old = pipe_q[0]; prev = pipe_q[1];
    erv0 = 1'b0; erv1 = 1'b0;
    if (old.v) begin
      if (old.we) ref_mem[old.addr] = old.data;
      else begin
        exp_rd[old.port] = ref_mem[old.addr];
        if (old.port) erv1 = 1'b1; else erv0 = 1'b1;
      end
    end
    eg0 = 1'b0; eg1 = 1'b0;
    if (p0_req && p1_req) begin
      if (m_last) eg0 = 1'b1; else eg1 = 1'b1;
    end else begin
      eg0 = p0_req; eg1 = p1_req;
    end
    act_g0 = p0_gnt; act_g1 = p1_gnt; act_rv0 = p0_rvalid; act_rv1 = p1_rvalid;
    act_rd0 = p0_rdata; act_rd1 = p1_rdata;
    chk("gnt0", p0_gnt, eg0);
    chk("gnt1", p1_gnt, eg1);
    chk("rvalid0", p0_rvalid, erv0);
    chk("rvalid1", p1_rvalid, erv1);
    chk("rdata0", p0_rdata, exp_rd[0]);
    chk("rdata1", p1_rdata, exp_rd[1]);
    chk("mem_read", mem_read, prev.v && !prev.we);
    chk("mem_write", mem_write, prev.v && prev.we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic model_commit();
    txn_t t;
    t = '0;
    if (eg0 || eg1) begin
      t.v = 1'b1; t.port = eg1;
      t.we   = eg1 ? p1_we    : p0_we;
      t.addr = eg1 ? p1_addr  : p0_addr;
      t.data = eg1 ? p1_wdata : p0_wdata;
      m_last = eg1; m_addr = t.addr; m_wdata = t.data;
    end
    void'(pipe_q.pop_front());
    pipe_q.push_back(t);
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic cyc(input vec_t v);
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    #1 eval_check();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_gnt0"}, p0_gnt, 0);       chk({tag, "_gnt1"}, p1_gnt, 0);
    chk({tag, "_rvalid0"}, p0_rvalid, 0); chk({tag, "_rvalid1"}, p1_rvalid, 0);
    chk({tag, "_rdata0"}, p0_rdata, 0);   chk({tag, "_rdata1"}, p1_rdata, 0);
    chk({tag, "_mem_read"}, mem_read, 0); chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0); chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic vec_t mk(logic r0, logic w0, logic [7:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic [7:0] a1, logic [7:0] d1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [1:0] rp, logic [7:0] rd);
    vec_t v;
    v = '{r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, v0, v1, rp, rd};
    return v;
  endfunction

  function automatic logic [7:0] rand_addr();
    return $urandom_range(1) != 0 ? 8'hF8 + 8'($urandom_range(7))
                                  : 8'h80 + 8'($urandom_range(7));
  endfunction

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = '0;
    reset = 1'b1; pre_en = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hC3;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
    check_reset_outs("reset");
    reset = 1'b0;

    // contention: both read every cycle from reset, grants alternate p0 first
    tbl.push_back(mk(1,0,8'h01,0, 1,0,8'h81,0, 1,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,8'h02,0, 1,0,8'h81,0, 0,1,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,8'h02,0, 1,0,8'h82,0, 1,0,1,0, 1,8'hC2));
    tbl.push_back(mk(1,0,8'h03,0, 1,0,8'h82,0, 0,1,0,1, 2,8'h42));
    tbl.push_back(mk(1,0,8'h03,0, 1,0,8'h83,0, 1,0,1,0, 1,8'hC1));
    tbl.push_back(mk(1,0,8'h04,0, 1,0,8'h83,0, 0,1,0,1, 2,8'h41));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,1,0, 1,8'hC0));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, 2,8'h40));
    // single port: p0 writes A5 to 3C, then reads it back
    tbl.push_back(mk(1,1,8'h3C,8'hA5, 0,0,0,0, 1,0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,8'h3C,8'h00, 0,0,0,0, 1,0,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,0, 0,0,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,0, 0,0,1,0, 1,8'hA5));
    // RAW: p1 writes 77 to FF, p0 reads FF the next cycle
    tbl.push_back(mk(0,0,8'h00,0, 1,1,8'hFF,8'h77, 0,1,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,8'hFF,0, 0,0,8'h00,8'h00, 1,0,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,8'h00, 0,0,0,0, 0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,8'h00, 0,0,1,0, 1,8'h77));

    foreach (tbl[k]) begin
      cyc(tbl[k]);
      chk($sformatf("tbl%0d_gnt0", k), act_g0, tbl[k].eg0);
      chk($sformatf("tbl%0d_gnt1", k), act_g1, tbl[k].eg1);
      chk($sformatf("tbl%0d_rvalid0", k), act_rv0, tbl[k].erv0);
      chk($sformatf("tbl%0d_rvalid1", k), act_rv1, tbl[k].erv1);
      if (tbl[k].erp == 2'd1) chk($sformatf("tbl%0d_rdata0", k), act_rd0, tbl[k].erd);
      if (tbl[k].erp == 2'd2) chk($sformatf("tbl%0d_rdata1", k), act_rd1, tbl[k].erd);
    end

    // idle and bus isolation after a read returning 42
    cyc(mk(1,1,8'h20,8'h42, 0,0,0,0, 0,0,0,0, 0,0));
    cyc(mk(1,0,8'h20,8'h00, 0,0,0,0, 0,0,0,0, 0,0));
    cyc(idle);
    cyc(idle);
    chk("idle_rdata0_first", p0_rdata, 8'h42);
    for (int n = 0; n < 5; n++) begin
      cyc(idle);
      chk("idle_mem_read", mem_read, 0);
      chk("idle_mem_write", mem_write, 0);
      chk("idle_rdata0", p0_rdata, 8'h42);
      chk("idle_rvalid0", p0_rvalid, 0);
      chk("idle_rvalid1", p1_rvalid, 0);
      chk("idle_rdata_known", $isunknown({p0_rdata, p1_rdata}), 0);
    end

    // random traffic; each requester holds its command until granted
    begin
      vec_t rv;
      logic h0, h1;
      rv = '0; h0 = 1'b0; h1 = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if (!h0 && $urandom_range(3) != 0) begin
          h0 = 1'b1; rv.w0 = 1'($urandom_range(1)); rv.a0 = rand_addr(); rv.d0 = 8'($urandom);
        end
        if (!h1 && $urandom_range(3) != 0) begin
          h1 = 1'b1; rv.w1 = 1'($urandom_range(1)); rv.a1 = rand_addr(); rv.d1 = 8'($urandom);
        end
        rv.r0 = h0; rv.r1 = h1;
        cyc(rv);
        chk("rand_rdata_known", $isunknown({p0_rdata, p1_rdata}), 0);
        if (eg0) h0 = 1'b0;
        if (eg1) h1 = 1'b0;
      end
      cyc(idle);
      cyc(idle);
    end

    // reset mid-transaction: p0 write of 5A to 10 is granted, then dropped
    p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 8'h5A;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    #1 eval_check();
    chk("rst_wr_gnt0", p0_gnt, 1);
    @(posedge clk);
    model_commit();
    #2 reset = 1'b1;
    model_reset();
    #1 check_reset_outs("midreset");
    @(negedge clk);
    reset = 1'b0;
    cyc(mk(1,0,8'h10,8'h00, 0,0,0,0, 0,0,0,0, 0,0));
    cyc(idle);
    cyc(idle);
    chk("rst_dropped_rvalid0", act_rv0, 1);
    chk("rst_dropped_rdata0", p0_rdata, 8'hD3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port `data_mem` between two requesters: port 0, the core load/store path, and port 1, the loader/DMA path. It accepts at most one access per cycle using round-robin arbitration and registers the winning command onto the memory's control pins. It captures read data from the memory's combinational output and returns it to the originating port with a valid strobe. It sits directly in front of `data_mem`, and both requesters connect only through it.

## Interface
- `ADDR_W`, default 8: address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 8: data width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request; must hold until the matching `pX_gnt` is seen.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; must be stable while `pX_req` is high.
- `p0_addr`, `p1_addr`  in  ADDR_W  access address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational; request accepted this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered; read data valid, one-cycle pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_W  registered read data; holds its value between reads.
- `mem_addr`  out  ADDR_W  registered; to `data_mem` `addr`.
- `mem_read`  out  1  registered; to `ctrl_mem_read`.
- `mem_write`  out  1  registered; to `ctrl_mem_write`.
- `mem_wdata`  out  DATA_W  registered; to `data_in`.
- `mem_rdata`  in  DATA_W  from `data_out`; high-Z when `mem_read` = 0.

## Operation
- **Arbitration**
  - Only one requester active: it is granted.
  - Both active: the port not granted most recently wins.
  - `last_gnt` updates on every grant.
  - Reset value of `last_gnt` = 1, so port 0 wins the first contention.
- **Grant rule**
  - `pX_gnt = pX_req & win_X`.
  - At most one grant per cycle.
  - No grant when neither port requests.
- **Command stage**
  - On a grant, register `mem_addr`, `mem_wdata`, `mem_read = ~we`, `mem_write = we`, and `src = X`.
  - With no grant, `mem_read` = `mem_write` = 0 on the next cycle. `mem_addr` and `mem_wdata` hold their values.
  - `mem_read` and `mem_write` are never both 1.
- **Read return**
  - When `mem_read` = 1, sample `mem_rdata` at the next clock edge into `pSRC_rdata`.
  - Pulse `pSRC_rvalid` for one cycle.
  - The other port's `rdata` and `rvalid` are unaffected.
  - `mem_rdata` is never sampled when `mem_read` = 0, because the bus is high-Z then.
- **Writes** produce no response; the grant is the only acknowledgment.
- **Reset** (asynchronous, any cycle, including mid-transaction)
  - `pX_rvalid` = 0, `pX_rdata` = 0.
  - `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `src` = 0, `last_gnt` = 1.
  - Any in-flight command is dropped: a pending write does not commit and a pending read returns no `rvalid`.
  - `pX_gnt` is forced to 0 while `reset` is high.

## Timing
- **Cycle T:** requester asserts `req`; `gnt` is high in the same cycle if it wins. The requester may change or drop `req` at edge T+1.
- **Cycle T+1:** the memory command is driven. A write commits to memory at edge T+2. A read is captured at edge T+2.
- **Cycle T+2:** `rvalid` = 1 with `rdata`. Read latency is 2 cycles from grant.
- **Throughput:** one access per cycle sustained. Back-to-back grants to the same port are allowed when the other port is idle.
- **Contention:** with both ports requesting continuously, grants alternate every cycle. Neither port waits more than 1 cycle.
- **Write-then-read, same address:** a write granted at T and a read granted at T+1 return the new data at T+3, because the write committed at edge T+2 before the read command cycle.
- **Full address range:** 0 to 2^ADDR_W−1, with no wrap or remap. Address 8'hFF is a valid access.

## Test plan
- **Reset:** assert `reset` mid-cycle with `p0` granted a write of 8'h5A to 8'h10. Required:
  - all outputs 0 immediately;
  - a later read of 8'h10 does not return 8'h5A.
- **Single port:**
  - `p0` writes 8'hA5 to 8'h3C, then reads 8'h3C;
  - `p0_gnt` is high in both request cycles;
  - `p0_rvalid` pulses 2 cycles after the read grant with `p0_rdata` = 8'hA5;
  - `p1_rvalid` stays 0.
- **Contention:**
  - both ports read continuously for 6 cycles from reset;
  - grants follow p0, p1, p0, p1, p0, p1;
  - each `rvalid`/`rdata` is returned to the correct port with that port's address contents.
- **RAW hazard:**
  - `p1` writes 8'h77 to 8'hFF at T; `p0` reads 8'hFF at T+1;
  - `p0_rdata` = 8'h77 with `p0_rvalid` at T+3.
- **Idle and bus isolation:**
  - no requests for 5 cycles after a read returning 8'h42;
  - `mem_read` = `mem_write` = 0 throughout;
  - `p0_rdata` holds 8'h42 and no `rvalid` pulses occur;
  - no X or Z ever appears on `pX_rdata`.
